audio_i2s_tx: RTL and testbench
===============================

Name: audio_i2s_tx

Overview:
- Output end of the discrete sound chain: receives signed 16-bit samples strobed by audio_clk_en from a sound circuit or final mixer.
- Buffers samples in a small FIFO so the sample-producing side and the serial side may drift.
- Serializes each sample as a standard I2S stereo frame, mono duplicated to left and right, for an external DAC.
- Generates its own BCLK/LRCK from clk.

Parameters:
- CLOCK_RATE, 24576000: clk frequency [Hz].
- SAMPLE_RATE, 48000: frame rate [Hz]. HALF = CLOCK_RATE/(SAMPLE_RATE*64) must be an integer >= 2, else elaboration error (default HALF=8).
- FIFO_DEPTH, 4: sample FIFO entries, power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- I_RSTn  in  1  reset.
- audio_clk_en  in  1  one-clk strobe; in is valid when high.
- in  in  16  signed sample, two's complement.
- out_bclk  out  1  I2S bit clock, 32 BCLK per frame.
- out_lrck  out  1  word select, 0 = left, 1 = right.
- out_sdata  out  1  serial data, MSB first.
- underrun  out  1  one-clk pulse: frame started with FIFO empty.
- overrun  out  1  one-clk pulse: sample dropped because FIFO full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count.

Behaviour:
- Reset and clocking: reset I_RSTn, asynchronous, active-low; clock clk. All state is registered on clk; no logic runs on out_bclk.
- Reset values: out_bclk=0, out_lrck=1, out_sdata=0, underrun=0, overrun=0, fifo_level=0. Also div_cnt=0, bit_cnt=31, hold=0, shift=0, primed=0.
- Divider: div_cnt counts 0..HALF-1. At HALF-1 it wraps and out_bclk toggles.
  - A toggle while out_bclk=1 is a "fall event". All serial outputs update only on fall events, in the same clk as the toggle.
  - First fall event occurs 2*HALF clks after reset release.
- On a fall event:
  - bit_cnt <= bit_cnt+1 mod 32.
  - out_lrck <= (new bit_cnt >= 16).
- I2S one-bit delay:
  - When new bit_cnt==0: pop FIFO into hold.
    - If the FIFO is empty, hold keeps its previous value (repeat last sample).
    - If the FIFO is empty and primed=1, pulse underrun.
  - When new bit_cnt==1: shift <= {hold,hold}; out_sdata <= hold[15].
  - Otherwise: out_sdata <= next shift bit, MSB first.
  - Net result: left MSB appears at bit_cnt 1 and right LSB appears at bit_cnt 0 of the following frame.
- FIFO write: on audio_clk_en, write in and set primed=1.
  - If the FIFO is full and no pop occurs in the same clk, drop the sample, pulse overrun, and leave contents unchanged.
  - Simultaneous push and pop when full: both occur, level unchanged, no overrun.
  - Simultaneous push and pop when empty: the pop sees empty, so the underrun rule applies and the pushed sample remains (level becomes 1).
- Pointers wrap mod FIFO_DEPTH. fifo_level is registered and reflects the post-update count in the same clk edge.
- No arithmetic on sample values. Bit-exact: the output word equals the input word.
- Reset mid-frame: all outputs return to reset values immediately (async). The FIFO is emptied and primed is cleared. The frame restarts cleanly after release.

Test Plan:
- Reset and first frame: release reset, no writes.
  - out_lrck=1 until clk 16 after release, then falls.
  - out_bclk period is 16 clks.
  - out_sdata stays 0.
  - underrun never pulses (primed=0).
- Single sample 0x8001: write at clk 100.
  - At the frame starting on the next lrck fall, the left slot at bit_cnt 1..16 shifts 1,0,...,0,1.
  - The right slot at bit_cnt 17..31 plus the next bit_cnt 0 repeats the same 16 bits.
- Steady stream: write the ramp 0x0000, 0x0101, ... every 512 clks, phase-locked.
  - Each frame carries the next ramp value on both channels.
  - fifo_level stays at 0/1; no underrun or overrun over 100 frames.
- Underrun: after sample 0x1234, stop writing.
  - The next frame repeats 0x1234.
  - underrun pulses exactly once per frame, for one clk, at bit_cnt wrap to 0.
- Overrun: write 6 samples 0x0011..0x0016 on consecutive clks within one frame, FIFO_DEPTH=4.
  - fifo_level reaches 4; overrun pulses on the 5th and 6th writes.
  - Following frames output 0x0011, 0x0012, 0x0013, 0x0014.
- Reset mid-frame: assert I_RSTn low at bit_cnt 9 with 3 entries queued.
  - All outputs take reset values asynchronously and fifo_level=0.
  - After release, timing matches the first scenario.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: buffers 16-bit samples and serialises them as I2S stereo frames,
//   mono duplicated to both channels, with BCLK/LRCK derived from clk.
// Latency: a queued sample leaves at the next frame start; left MSB one BCLK after LRCK falls.
// Backpressure: none; a write while full is dropped (overrun), a frame with no data repeats (underrun).
// Ports: clk, I_RSTn (async active-low); audio_clk_en/in = sample strobe and data;
//   out_bclk/out_lrck/out_sdata = I2S bus; underrun/overrun = one-clk pulses; fifo_level = entries.
module audio_i2s_tx #(
  parameter int CLOCK_RATE  = 24576000,
  parameter int SAMPLE_RATE = 48000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          I_RSTn,
  input  logic                          audio_clk_en,
  input  logic [15:0]                   in,
  output logic                          out_bclk,
  output logic                          out_lrck,
  output logic                          out_sdata,
  output logic                          underrun,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int HALF = CLOCK_RATE / (SAMPLE_RATE * 64);
  localparam int DW   = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

  if (HALF < 2 || (CLOCK_RATE % (SAMPLE_RATE * 64)) != 0) begin : g_bad_rate
    $error("audio_i2s_tx: CLOCK_RATE/(SAMPLE_RATE*64) must be an integer >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("audio_i2s_tx: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [15:0]   hold;
  logic [31:0]   shift;
  logic          primed;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   mem [FIFO_DEPTH];

  logic          div_wrap;
  logic          fall;
  logic [4:0]    bit_nxt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;

  always_comb begin
    div_wrap   = (div_cnt == DW'(HALF - 1));
    fall       = div_wrap && out_bclk;
    bit_nxt    = bit_cnt + 5'd1;
    fifo_empty = (fifo_level == '0);
    fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
    // The pop only sees entries already present, so a push in the same clk
    // cannot satisfy an empty-FIFO frame start.
    pop        = fall && (bit_nxt == 5'd0) && !fifo_empty;
    // A full FIFO still accepts when a pop frees a slot in the same clk.
    push_ok    = audio_clk_en && (!fifo_full || pop);
  end

  // Sample storage carries no reset; the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      div_cnt    <= '0;
      out_bclk   <= 1'b0;
      out_lrck   <= 1'b1;
      out_sdata  <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
      bit_cnt    <= 5'd31;
      hold       <= '0;
      shift      <= '0;
      primed     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      underrun <= 1'b0;
      overrun  <= 1'b0;

      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) out_bclk <= ~out_bclk;

      if (fall) begin
        bit_cnt  <= bit_nxt;
        out_lrck <= bit_nxt[4];
        if (bit_nxt == 5'd1) begin
          // MSB goes out now; the rest of both copies is queued so that the
          // right-channel LSB lands on bit 0 of the next frame.
          out_sdata <= hold[15];
          shift     <= {hold[14:0], hold, 1'b0};
        end else begin
          out_sdata <= shift[31];
          shift     <= {shift[30:0], 1'b0};
        end
        if (bit_nxt == 5'd0) begin
          if (!fifo_empty) hold <= mem[rd_ptr];
          else if (primed) underrun <= 1'b1;
        end
      end

      if (audio_clk_en) begin
        primed <= 1'b1;
        if (!push_ok) overrun <= 1'b1;
      end

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed bench for audio_i2s_tx with default parameters (HALF=8, depth 4).
// Decodes the serial stream at each BCLK fall and compares against hand-computed words.
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        I_RSTn = 1'b0;
  logic        audio_clk_en = 1'b0;
  logic [15:0] smp = 16'h0000;
  logic        out_bclk, out_lrck, out_sdata, underrun, overrun;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  int und_cnt = 0;
  int und_bad = 0;
  int ovr_cnt = 0;
  int lvl_max = 0;
  int sd_ones = 0;

  always #5 clk = ~clk;

  audio_i2s_tx dut (
    .clk         (clk),
    .I_RSTn      (I_RSTn),
    .audio_clk_en(audio_clk_en),
    .in          (smp),
    .out_bclk    (out_bclk),
    .out_lrck    (out_lrck),
    .out_sdata   (out_sdata),
    .underrun    (underrun),
    .overrun     (overrun),
    .fifo_level  (fifo_level)
  );

  // Pulses last one clk, so one negedge sample per high clk.
  always @(negedge clk) begin
    if (underrun) begin
      und_cnt++;
      if (out_lrck !== 1'b0 || out_bclk !== 1'b0) und_bad++;
    end
    if (overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    audio_clk_en = 1'b1;
    smp = v;
    tick();
    audio_clk_en = 1'b0;
  endtask

  task automatic next_fall();
    logic p;
    bit   done;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      p = out_bclk;
      tick();
      if (p && !out_bclk) done = 1;
    end
    if (!done) check("fall_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frame_start();
    logic p;
    bit   done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      p = out_lrck;
      next_fall();
      if (p && !out_lrck) done = 1;
    end
    if (!done) check("frame_timeout", 32'd0, 32'd1);
  endtask

  // Called just after a bit-0 fall; returns just after the next bit-0 fall.
  task automatic collect(output logic [15:0] l, output logic [15:0] r);
    l = '0;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      next_fall();
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      if (i < 16) l = {l[14:0], out_sdata};
      else        r = {r[14:0], out_sdata};
    end
  endtask

  task automatic do_reset();
    I_RSTn = 1'b0;
    repeat (3) tick();
    check("rst_bclk",  {31'd0, out_bclk},  32'd0);
    check("rst_lrck",  {31'd0, out_lrck},  32'd1);
    check("rst_sdata", {31'd0, out_sdata}, 32'd0);
    check("rst_undr",  {31'd0, underrun},  32'd0);
    check("rst_ovr",   {31'd0, overrun},   32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    I_RSTn = 1'b1;
  endtask

  task automatic first_frame_checks();
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (out_sdata) sd_ones++;
      if (e == 7)  check("ff_bclk_e7",  {31'd0, out_bclk}, 32'd0);
      if (e == 8)  check("ff_bclk_e8",  {31'd0, out_bclk}, 32'd1);
      if (e == 15) check("ff_lrck_e15", {31'd0, out_lrck}, 32'd1);
      if (e == 16) check("ff_lrck_e16", {31'd0, out_lrck}, 32'd0);
      if (e == 16) check("ff_bclk_e16", {31'd0, out_bclk}, 32'd0);
      if (e == 24) check("ff_bclk_e24", {31'd0, out_bclk}, 32'd1);
      if (e == 32) check("ff_bclk_e32", {31'd0, out_bclk}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] l, r, v;
    int u0, o0;

    // Reset and first frame with no writes.
    do_reset();
    first_frame_checks();
    repeat (67) begin
      tick();
      if (out_sdata) sd_ones++;
    end
    check("ff_sdata_ones", sd_ones, 0);
    check("ff_no_underrun", und_cnt, 0);

    // Single sample 0x8001 written around clk 100, then 0x1234 and underrun.
    push(16'h8001);
    wait_frame_start();
    push(16'h1234);
    collect(l, r);
    check("s8001_left",  {16'd0, l}, 32'h8001);
    check("s8001_right", {16'd0, r}, 32'h8001);
    tick();
    u0 = und_cnt;
    check("s8001_no_undr", und_cnt, u0);
    collect(l, r);
    check("s1234_left",  {16'd0, l}, 32'h1234);
    check("s1234_right", {16'd0, r}, 32'h1234);
    tick();
    check("undr_first", und_cnt - u0, 1);
    collect(l, r);
    check("undr_rep_left",  {16'd0, l}, 32'h1234);
    check("undr_rep_right", {16'd0, r}, 32'h1234);
    tick();
    check("undr_second", und_cnt - u0, 2);
    check("undr_position", und_bad, 0);

    // Steady phase-locked ramp; frame k carries ramp value k-1.
    lvl_max = 0;
    o0 = ovr_cnt;
    for (int k = 0; k < 12; k++) begin
      push(16'(k * 257));
      if (k == 0) u0 = und_cnt;
      collect(l, r);
      v = (k == 0) ? 16'h1234 : 16'((k - 1) * 257);
      check("ramp_left",  {16'd0, l}, {16'd0, v});
      check("ramp_right", {16'd0, r}, {16'd0, v});
    end
    tick();
    check("ramp_no_undr", und_cnt - u0, 0);
    check("ramp_no_ovr",  ovr_cnt - o0, 0);
    check("ramp_lvl_max", lvl_max, 1);

    // Overrun: six writes on consecutive clks into a depth-4 FIFO.
    o0 = ovr_cnt;
    for (int i = 0; i < 6; i++) begin
      push(16'(16'h0011 + i));
      check("ovr_level", {29'd0, fifo_level}, (i < 4) ? (i + 1) : 4);
      check("ovr_pulse", {31'd0, overrun}, (i >= 4) ? 1 : 0);
    end
    tick();
    check("ovr_count", ovr_cnt - o0, 2);
    wait_frame_start();
    for (int i = 0; i < 4; i++) begin
      collect(l, r);
      check("ovr_frame_left",  {16'd0, l}, 32'h0011 + i);
      check("ovr_frame_right", {16'd0, r}, 32'h0011 + i);
    end

    // Reset mid-frame at bit 9 with three entries queued.
    push(16'hAAAA);
    push(16'h5555);
    push(16'hF00F);
    check("mid_level3", {29'd0, fifo_level}, 32'd3);
    repeat (9) next_fall();
    check("mid_lrck_pre", {31'd0, out_lrck}, 32'd0);
    I_RSTn = 1'b0;
    #1;
    check("mid_async_lrck",  {31'd0, out_lrck},   32'd1);
    check("mid_async_bclk",  {31'd0, out_bclk},   32'd0);
    check("mid_async_sdata", {31'd0, out_sdata},  32'd0);
    check("mid_async_level", {29'd0, fifo_level}, 32'd0);
    do_reset();
    first_frame_checks();
    u0 = und_cnt;
    wait_frame_start();
    collect(l, r);
    check("post_rst_left",  {16'd0, l}, 32'h0000);
    check("post_rst_right", {16'd0, r}, 32'h0000);
    tick();
    check("post_rst_no_undr", und_cnt - u0, 0);
    check("post_rst_level", {29'd0, fifo_level}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
